// File: rtl/nibble_packer.sv
// Packs four consecutive synchronized nibbles (first nibble in the MSBs) into a
// 16-bit word and queues completed words in a small FIFO drained by valid/ready.
module nibble_packer #(
    parameter int DEPTH = 4
) (
    input  logic                     fast_clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [3:0]               in_data,
    input  logic                     clr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [1:0]    ncntQ, ncntD;
    logic [15:0]   srQ, srD;
    logic [15:0]   memQ [DEPTH];
    logic [PW-1:0] wptrQ, wptrD;
    logic [PW-1:0] rptrQ, rptrD;
    logic [LW-1:0] levelQ, levelD;
    logic          overflowQ, overflowD;

    logic        full;
    logic        push;
    logic        pop;
    logic        accept;
    logic        drop;
    logic [15:0] word;

    // A full FIFO still takes a word when the head leaves on the same edge.
    assign full   = (levelQ == LW'(DEPTH));
    assign pop    = (levelQ != '0) && out_ready;
    assign push   = in_valid && !clr && (ncntQ == 2'd3);
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;
    assign word   = {srQ[15:4], in_data};

    always_comb begin
        ncntD     = ncntQ;
        srD       = srQ;
        wptrD     = wptrQ;
        rptrD     = rptrQ;
        levelD    = levelQ;
        overflowD = overflowQ | drop;

        if (clr) begin
            ncntD     = 2'd0;
            srD       = 16'h0000;
            overflowD = 1'b0;
        end else if (in_valid) begin
            ncntD = ncntQ + 2'd1;
            case (ncntQ)
                2'd0:    srD[15:12] = in_data;
                2'd1:    srD[11:8]  = in_data;
                2'd2:    srD[7:4]   = in_data;
                default: srD[3:0]   = in_data;
            endcase
        end

        if (accept) begin
            wptrD = wptrQ + PW'(1);
        end
        if (pop) begin
            rptrD = rptrQ + PW'(1);
        end

        case ({accept, pop})
            2'b10:   levelD = levelQ + LW'(1);
            2'b01:   levelD = levelQ - LW'(1);
            default: levelD = levelQ;
        endcase
    end

    always_ff @(posedge fast_clk) begin
        if (rst) begin
            ncntQ     <= 2'd0;
            srQ       <= 16'h0000;
            wptrQ     <= '0;
            rptrQ     <= '0;
            levelQ    <= '0;
            overflowQ <= 1'b0;
        end else begin
            ncntQ     <= ncntD;
            srQ       <= srD;
            wptrQ     <= wptrD;
            rptrQ     <= rptrD;
            levelQ    <= levelD;
            overflowQ <= overflowD;
        end
    end

    // Storage is zeroed on reset so out_data never shows X.
    always_ff @(posedge fast_clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                memQ[i] <= 16'h0000;
            end
        end else if (accept) begin
            memQ[wptrQ] <= word;
        end
    end

    assign out_valid = (levelQ != '0);
    assign out_data  = memQ[rptrQ];
    assign level     = levelQ;
    assign overflow  = overflowQ;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (DEPTH=4): pack order, fill and
// overflow, push/pop at full, mid-word clr/rst, and a back-to-back wrap run.
module tb_nibble_packer;

    localparam int DEPTH = 4;

    logic        fast_clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  level;
    logic        overflow;

    int testCount = 0;
    int failCount = 0;

    nibble_packer #(.DEPTH(DEPTH)) dut (
        .fast_clk  (fast_clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic expValid, input logic [15:0] expData,
                               input int expLevel, input logic expOvf);
        checkVal({tag, "_valid"}, 16'(out_valid), 16'(expValid));
        checkVal({tag, "_level"}, 16'(level), 16'(expLevel));
        checkVal({tag, "_ovf"}, 16'(overflow), 16'(expOvf));
        if (expValid) begin
            checkVal({tag, "_data"}, out_data, expData);
        end
    endtask

    // One clock with the given inputs, then inputs return to idle.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic c, input logic r);
        in_valid  = v;
        in_data   = d;
        clr       = c;
        out_ready = r;
        tick();
        in_valid  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic pushWord(input logic [15:0] w, input logic lastReady);
        applyStimulus(1'b1, w[15:12], 1'b0, 1'b0);
        applyStimulus(1'b1, w[11:8],  1'b0, 1'b0);
        applyStimulus(1'b1, w[7:4],   1'b0, 1'b0);
        applyStimulus(1'b1, w[3:0],   1'b0, lastReady);
    endtask

    logic [15:0] fillWords [4];
    logic [15:0] q [$];
    logic [15:0] tmp;
    logic [11:0] part;
    int          mcnt;
    logic        movf;
    logic        mpop;
    logic        mfull;
    logic [3:0]  d;
    logic        r;

    initial begin
        fillWords[0] = 16'h1111;
        fillWords[1] = 16'h2222;
        fillWords[2] = 16'h3333;
        fillWords[3] = 16'h4444;

        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; clr = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset", 1'b0, 16'h0000, 0, 1'b0);
        checkVal("reset_data_noX", out_data, 16'h0000);

        pushWord(16'hABCD, 1'b0);
        checkOutput("pack", 1'b1, 16'hABCD, 1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        checkOutput("pack_pop", 1'b0, 16'h0000, 0, 1'b0);

        for (int i = 0; i < 4; i++) pushWord(fillWords[i], 1'b0);
        checkOutput("fill", 1'b1, 16'h1111, 4, 1'b0);
        pushWord(16'h5555, 1'b0);
        checkOutput("overflow", 1'b1, 16'h1111, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkVal("drain_data", out_data, fillWords[i]);
            applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        end
        checkOutput("drained", 1'b0, 16'h0000, 0, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        checkOutput("clr_ovf", 1'b0, 16'h0000, 0, 1'b0);

        // Full FIFO, head pops on the edge that completes 0x6666.
        for (int i = 0; i < 4; i++) pushWord(fillWords[i], 1'b0);
        pushWord(16'h6666, 1'b1);
        checkOutput("pushpop_full", 1'b1, 16'h2222, 4, 1'b0);
        checkVal("pp_drain0", out_data, 16'h2222); applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        checkVal("pp_drain1", out_data, 16'h3333); applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        checkVal("pp_drain2", out_data, 16'h4444); applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        checkVal("pp_drain3", out_data, 16'h6666); applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        checkOutput("pp_empty", 1'b0, 16'h0000, 0, 1'b0);

        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
        pushWord(16'h3456, 1'b0);
        checkOutput("mid_clr", 1'b1, 16'h3456, 1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);

        // A nibble strobed together with clr is lost as well.
        applyStimulus(1'b1, 4'h9, 1'b1, 1'b0);
        pushWord(16'h789A, 1'b0);
        checkOutput("clr_with_valid", 1'b1, 16'h789A, 1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);

        pushWord(16'h1111, 1'b0);
        pushWord(16'h2222, 1'b0);
        applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
        checkOutput("pre_rst", 1'b1, 16'h1111, 2, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 4'h7, 1'b1, 1'b1);
        rst = 1'b0;
        checkOutput("mid_rst", 1'b0, 16'h0000, 0, 1'b0);
        pushWord(16'h3456, 1'b0);
        checkOutput("after_rst", 1'b1, 16'h3456, 1, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        checkOutput("after_rst_pop", 1'b0, 16'h0000, 0, 1'b0);

        // Back-to-back nibbles against a queue reference model.
        q.delete();
        part = 12'h000;
        mcnt = 0;
        movf = 1'b0;
        for (int i = 0; i < 40; i++) begin
            d = 4'(i);
            r = (i % 2) == 1;
            in_valid  = 1'b1;
            in_data   = d;
            out_ready = r;
            mfull = (q.size() == DEPTH);
            mpop  = r && (q.size() != 0);
            if (mpop) begin
                checkVal("b2b_data", out_data, q[0]);
                tmp = q.pop_front();
            end
            if (mcnt == 3) begin
                if (mfull && !mpop) movf = 1'b1;
                else q.push_back({part, d});
            end else begin
                part = {part[7:0], d};
            end
            mcnt = (mcnt + 1) % 4;
            tick();
            checkOutput("b2b", q.size() != 0, (q.size() != 0) ? q[0] : 16'h0000, q.size(), movf);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        while (q.size() != 0) begin
            checkVal("b2b_tail", out_data, q[0]);
            tmp = q.pop_front();
            applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
        end
        checkOutput("b2b_end", 1'b0, 16'h0000, 0, movf);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/nibble_packer.md
# nibble_packer

Fast-clock-domain stage directly downstream of the slow-to-fast toggle synchronizer. It takes each synchronized 4-bit nibble strobe and packs four consecutive nibbles into a 16-bit word. Completed words go into a small FIFO, which a consumer drains through a valid/ready handshake. A sticky flag reports words dropped because the FIFO was full.

## Interface
- `DEPTH`, default 4: FIFO depth in words. Power of two, 2..16.
- Derived localparam `LW` = log2(DEPTH)+1: width of `level`.
- `fast_clk` input 1: the only clock; everything is sampled on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: single-cycle nibble strobe, driven by the synchronizer's `sync_clk` pulse.
- `in_data` input 4: nibble, qualified by `in_valid`.
- `clr` input 1: synchronous clear of the partial word and the overflow flag.
- `out_valid` output 1: FIFO head word is available.
- `out_ready` input 1: consumer accepts the head word when `out_valid` and `out_ready` are both high.
- `out_data` output 16: FIFO head word; meaningful only while `out_valid` is high.
- `level` output LW: number of words currently stored, 0..DEPTH.
- `overflow` output 1: sticky; set when a completed word is dropped.

## Operation
- **Nibble counter `ncnt` (2 bits).** On each cycle with `in_valid` high:
  - `in_data` is written into the shift register at position `ncnt`.
  - Placement: the first nibble goes to [15:12], the second to [11:8], the third to [7:4], the fourth to [3:0].
  - `ncnt` then increments, wrapping 3 to 0.
- **Word completion.** The 4th nibble (`ncnt`==3 with `in_valid` high) completes a word, made of the three buffered nibbles plus `in_data`. That word is pushed into the FIFO on the same edge.
- **Push when full.** A push with `level`==DEPTH and no pop on the same cycle drops the word and sets `overflow`. `ncnt` still wraps to 0. FIFO contents are unchanged.
- **Push and pop together.** A push with `level`==DEPTH and a pop on the same cycle is accepted. `level` stays at DEPTH and `overflow` is not set.
- **Pop.** A pop (`out_valid` and `out_ready`) advances the read pointer.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap naturally. `level` changes by +1 (push only), -1 (pop only) or 0 (both or neither).
- **Outputs.** `out_valid` = (`level` != 0). `out_data` = the storage entry at the read pointer.
- **`clr`:**
  - Forces `ncnt` to 0, discards the partial word and clears `overflow`.
  - Does not touch FIFO contents, pointers or `level`.
  - If `in_valid` is high in the same cycle, that nibble is discarded.
  - A pop in the same cycle still completes.
- **`rst`:**
  - Clears `ncnt`, pointers, `level` and `overflow`, and zeroes the shift register.
  - Takes priority over `clr`, `in_valid` and `out_ready`.
  - Reset mid-word discards the partial nibbles. Reset with a non-empty FIFO empties it.
- **Reset values:** `out_valid`=0, `level`=0, `overflow`=0. `out_data` is don't-care while `out_valid`=0, but the bench must not see X after reset, so storage is zeroed at reset.
- **Input protocol.** `in_valid` may be high on consecutive cycles. There is no backpressure on the input side; loss is reported only through `overflow`.

## Timing
- Latency: 4th nibble strobe at edge N; `out_valid` high and `out_data` valid after edge N, i.e. observable in cycle N+1 when the FIFO was empty.
- Pop at edge M: the next word appears, or `out_valid` drops, after edge M.
- `overflow` rises after the edge that dropped the word and stays high until `clr` or `rst`.
- `out_valid` and `level` are registered-state functions with no combinational path from `out_ready` or `in_valid`. `out_data` is a mux of registers.
- Sustained throughput: one word per 4 input strobes; one pop per cycle on the output.

## Test plan
- **Reset:** assert `rst` for 2 cycles -> `out_valid`=0, `level`=0, `overflow`=0, no X on any output.
- **Pack order:** `out_ready`=0; strobe nibbles 0xA, 0xB, 0xC, 0xD -> one cycle after the 4th strobe, `out_valid`=1, `out_data`=0xABCD, `level`=1. Raise `out_ready` for 1 cycle -> `out_valid`=0, `level`=0.
- **Fill and overflow (DEPTH=4), in order:**
  - Push 4 words 0x1111..0x4444 with `out_ready`=0 -> `level`=4, `overflow`=0.
  - Push a 5th word 0x5555 -> `overflow`=1, `level`=4.
  - Drain -> reads 0x1111, 0x2222, 0x3333, 0x4444; 0x5555 is never seen.
- **Simultaneous push/pop at full:** FIFO full, `out_ready`=1 on the 4th-nibble cycle of word 0x6666 -> `overflow` stays 0, `level` stays 4, and 0x6666 is read last.
- **Mid-word clr/rst:**
  - Strobe 0x1, 0x2, pulse `clr`, then strobe 0x3, 0x4, 0x5, 0x6 -> word 0x3456 is stored.
  - Same sequence with `rst` in place of `clr` and 2 words queued -> FIFO empty, then 0x3456 is the only word.
- **Back-to-back and wrap:** `in_valid` held high for 40 cycles with an incrementing nibble 0x0..0xF repeating, and `out_ready` toggling every cycle -> every popped word equals four consecutive input nibbles with no reorder. Pointers wrap at least twice. `overflow` follows a reference model exactly.
